// File: rtl/de_issue_ctrl_pkg.sv
// rtl/de_issue_ctrl_pkg.sv - shared types and defaults for the decode issue controller
package de_issue_ctrl_pkg;
  localparam int REGNO_BITS_DEF = 5;
  localparam int CNT_BITS_DEF   = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/de_issue_ctrl_sb_counter.sv
// rtl/de_issue_ctrl_sb_counter.sv - saturating up/down pending-write counter for one register
module sb_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [CNT_BITS-1:0] count,
  output logic                zero,
  output logic                max,
  output logic                err
);
  assign zero = (count == '0);
  assign max  = (count == '1);
  // Simultaneous inc and dec cancel and are never an error.
  assign err  = (dec && !inc && zero) || (inc && !dec && max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec && !max) begin
      count <= count + CNT_BITS'(1);
    end else if (dec && !inc && !zero) begin
      count <= count - CNT_BITS'(1);
    end
  end
endmodule

// File: rtl/de_issue_ctrl.sv
// rtl/de_issue_ctrl.sv - decode issue controller: register scoreboard, hazard check, flush sequencer
module de_issue_ctrl
  import de_issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int REGNO_BITS   = REGNO_BITS_DEF,
  parameter int CNT_BITS     = CNT_BITS_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  de_valid,
  input  logic                  de_use_rs1,
  input  logic                  de_use_rs2,
  input  logic [REGNO_BITS-1:0] de_rs1,
  input  logic [REGNO_BITS-1:0] de_rs2,
  input  logic                  de_wr_reg,
  input  logic [REGNO_BITS-1:0] de_rd,
  input  logic                  wb_wr_reg,
  input  logic [REGNO_BITS-1:0] wb_wregno,
  input  logic                  br_mispred_agex,
  output logic                  issue_de,
  output logic                  stall_de,
  output logic                  flushing,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  sb_err
);
  localparam int FC_BITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_BITS-1:0] FC_LOAD = FC_BITS'(FLUSH_CYCLES - 1);

  state_t              state, state_nx;
  logic [FC_BITS-1:0]  fcnt, fcnt_nx;
  logic [CNT_BITS-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec, zero_v, max_v, err_v;
  logic                wb_rs1, wb_rs2, wb_rd, raw_hazard, sat_hazard;

  assign cnt[0]    = '0;
  assign inc[0]    = 1'b0;
  assign dec[0]    = 1'b0;
  assign zero_v[0] = 1'b1;
  assign max_v[0]  = 1'b0;
  assign err_v[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_sb
    assign inc[i] = issue_de && de_wr_reg && (de_rd == REGNO_BITS'(i));
    assign dec[i] = wb_wr_reg && (wb_wregno == REGNO_BITS'(i));
    sb_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .count (cnt[i]),
      .zero  (zero_v[i]),
      .max   (max_v[i]),
      .err   (err_v[i])
    );
  end

  assign pending_mask = ~zero_v;

  // A same-cycle WB retire of the last writer clears the hazard: the regfile writes on negedge.
  always_comb begin
    wb_rs1     = wb_wr_reg && (wb_wregno == de_rs1);
    wb_rs2     = wb_wr_reg && (wb_wregno == de_rs2);
    wb_rd      = wb_wr_reg && (wb_wregno == de_rd);
    raw_hazard = (de_use_rs1 && (de_rs1 != '0) && (cnt[de_rs1] > CNT_BITS'(wb_rs1))) ||
                 (de_use_rs2 && (de_rs2 != '0) && (cnt[de_rs2] > CNT_BITS'(wb_rs2)));
    sat_hazard = de_wr_reg && (de_rd != '0) && max_v[de_rd] && !wb_rd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    case (state)
      RUN: begin
        if (br_mispred_agex) begin
          state_nx = FLUSH;
          fcnt_nx  = FC_LOAD;
        end
      end
      FLUSH: begin
        if (br_mispred_agex) begin
          fcnt_nx = FC_LOAD;
        end else if (fcnt == '0) begin
          state_nx = RUN;
        end else begin
          fcnt_nx = fcnt - FC_BITS'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    issue_de = reset && de_valid && (state == RUN) && !br_mispred_agex &&
               !raw_hazard && !sat_hazard;
    stall_de = reset && ((de_valid && !issue_de) || (state == FLUSH) || br_mispred_agex);
    flushing = reset && (state == FLUSH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_err <= 1'b0;
    end else if (|err_v) begin
      sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_de_issue_ctrl.sv
// tb/tb_de_issue_ctrl.sv - randomized and directed self-checking bench for de_issue_ctrl
module tb_de_issue_ctrl;
  localparam int F = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        de_valid = 0, de_use_rs1 = 0, de_use_rs2 = 0, de_wr_reg = 0;
  logic [4:0]  de_rs1 = 0, de_rs2 = 0, de_rd = 0, wb_wregno = 0;
  logic        wb_wr_reg = 0, br_mispred_agex = 0;
  logic        issue_de, stall_de, flushing, sb_err;
  logic [31:0] pending_mask;

  int checks = 0;
  int failures = 0;

  int mcnt[32];
  bit m_err;
  int prev_mp;
  int cyc = 0;

  de_issue_ctrl #(.NUM_REGS(32), .REGNO_BITS(5), .CNT_BITS(2), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_wr_reg(de_wr_reg), .de_rd(de_rd),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .br_mispred_agex(br_mispred_agex),
    .issue_de(issue_de), .stall_de(stall_de), .flushing(flushing),
    .pending_mask(pending_mask), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wbhit(input int r);
    return (wb_wr_reg && wb_wregno == 5'(r) && r != 0) ? 1 : 0;
  endfunction

  function automatic int eff(input int r);
    return mcnt[r] - wbhit(r);
  endfunction

  // Reference model: evaluated every cycle mid-low-phase, then advanced to the post-edge state.
  always @(negedge clk) begin
    logic        e_flush, e_block, e_raw, e_sat, e_issue, e_stall;
    logic [31:0] e_mask;
    #2;
    cyc++;
    e_mask = '0;
    for (int r = 1; r < 32; r++) e_mask[r] = (mcnt[r] != 0);
    if (!reset) begin
      chk("rst_issue", 32'(issue_de), 0);
      chk("rst_stall", 32'(stall_de), 0);
      chk("rst_flushing", 32'(flushing), 0);
      chk("rst_pending", pending_mask, 0);
      chk("rst_sb_err", 32'(sb_err), 0);
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      m_err = 0;
      prev_mp = -1000;
    end else begin
      e_flush = (cyc > prev_mp) && (cyc - prev_mp <= F);
      e_block = e_flush || br_mispred_agex;
      e_raw = (de_use_rs1 && de_rs1 != 0 && eff(int'(de_rs1)) > 0) ||
              (de_use_rs2 && de_rs2 != 0 && eff(int'(de_rs2)) > 0);
      e_sat = de_wr_reg && de_rd != 0 && mcnt[de_rd] == 3 && wbhit(int'(de_rd)) == 0;
      e_issue = de_valid && !e_block && !e_raw && !e_sat;
      e_stall = (de_valid && !e_issue) || e_flush || br_mispred_agex;
      chk("issue_de", 32'(issue_de), 32'(e_issue));
      chk("stall_de", 32'(stall_de), 32'(e_stall));
      chk("flushing", 32'(flushing), 32'(e_flush));
      chk("pending_mask", pending_mask, e_mask);
      chk("sb_err", 32'(sb_err), 32'(m_err));
      for (int r = 1; r < 32; r++) begin
        int i_, d_;
        i_ = (e_issue && de_wr_reg && de_rd == 5'(r)) ? 1 : 0;
        d_ = wbhit(r);
        if (i_ == 1 && d_ == 0) begin
          if (mcnt[r] == 3) m_err = 1; else mcnt[r]++;
        end else if (d_ == 1 && i_ == 0) begin
          if (mcnt[r] == 0) m_err = 1; else mcnt[r]--;
        end
      end
      if (br_mispred_agex) prev_mp = cyc;
    end
  end

  task automatic drive(input logic v, input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2, input logic w,
                       input logic [4:0] rd, input logic wb, input logic [4:0] wn,
                       input logic mp);
    @(negedge clk);
    de_valid = v; de_use_rs1 = u1; de_rs1 = r1; de_use_rs2 = u2; de_rs2 = r2;
    de_wr_reg = w; de_rd = rd; wb_wr_reg = wb; wb_wregno = wn; br_mispred_agex = mp;
    #3;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    m_err = 0;
    prev_mp = -1000;

    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("lit_rst_issue", 32'(issue_de), 0);
    chk("lit_rst_stall", 32'(stall_de), 0);
    idle();
    reset = 1'b1;

    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("lit_wr_x5", 32'(issue_de), 1);
    drive(1, 1, 5, 1, 5, 1, 6, 0, 0, 0);
    chk("lit_raw_issue", 32'(issue_de), 0);
    chk("lit_raw_stall", 32'(stall_de), 1);
    drive(1, 1, 5, 1, 5, 1, 6, 1, 5, 0);
    chk("lit_raw_bypass", 32'(issue_de), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);

    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    chk("lit_two_wr_wb1", 32'(issue_de), 0);
    idle();
    chk("lit_x7_pending", 32'(pending_mask[7]), 1);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_x7_still_stall", 32'(issue_de), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    idle();
    chk("lit_x7_clear", 32'(pending_mask[7]), 0);

    repeat (3) drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("lit_sat_block", 32'(issue_de), 0);
    chk("lit_sat_no_err", 32'(sb_err), 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_mp_t0_issue", 32'(issue_de), 0);
    chk("lit_mp_t0_flush", 32'(flushing), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_mp_t1_flush", 32'(flushing), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_mp_t2_issue", 32'(issue_de), 0);
    chk("lit_mp_t2_flush", 32'(flushing), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_mp_t4_flush", 32'(flushing), 1);
    chk("lit_mp_t4_issue", 32'(issue_de), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_mp_t5_flush", 32'(flushing), 0);
    chk("lit_mp_t5_issue", 32'(issue_de), 1);

    drive(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 11, 1, 11, 0);
    chk("lit_inc_dec_issue", 32'(issue_de), 1);
    idle();
    chk("lit_inc_dec_hold", 32'(pending_mask[11]), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 11, 0);
    idle();
    chk("lit_x11_clear", 32'(pending_mask[11]), 0);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    idle();
    chk("lit_err_set", 32'(sb_err), 1);
    idle();
    chk("lit_err_sticky", 32'(sb_err), 1);

    for (int r = 12; r < 16; r++) drive(1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("lit_pre_rst_flush", 32'(flushing), 1);
    chk("lit_pre_rst_pend", 32'(pending_mask[15:12]), 32'hf);
    reset = 1'b0;
    #1;
    chk("lit_rst_pend", pending_mask, 0);
    chk("lit_rst_flush", 32'(flushing), 0);
    chk("lit_rst_err", 32'(sb_err), 0);
    idle();
    reset = 1'b1;
    drive(1, 1, 12, 1, 13, 0, 0, 0, 0, 0);
    chk("lit_post_rst_issue", 32'(issue_de), 1);

    for (int n = 0; n < 3000; n++) begin
      int q[$];
      logic wb;
      logic [4:0] wn;
      q = {};
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) q.push_back(r);
      wb = (q.size() > 0) && ($urandom % 2 == 0);
      wn = wb ? 5'(q[$urandom % q.size()]) : 5'($urandom_range(0, 31));
      if ($urandom % 200 == 0) begin
        @(negedge clk);
        reset = 1'b0;
        de_valid = 0; de_wr_reg = 0; wb_wr_reg = 0; br_mispred_agex = 0;
        #3;
        reset = 1'b1;
      end else begin
        drive($urandom % 4 != 0, 1'($urandom), 5'($urandom_range(0, 9)),
              1'($urandom), 5'($urandom_range(0, 9)), 1'($urandom),
              5'($urandom_range(0, 9)), wb, wn, $urandom % 25 == 0);
      end
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
